clint_regfile: RTL
==================

# clint_regfile

Register bank and timer core of the CLINT, directly downstream of the CLINT AXI-Lite slave. Consumes its RAM-like request (address, enable, write-enable, write data) and returns read data combinationally. Holds `msip`, `mtimecmp` per hart and the shared `mtime` counter. Produces the per-hart software and timer interrupts.

## Interface
- `NR_CORES`, 1: number of harts served (1..64).
- `AXI_ADDR_WIDTH`, 64: width of `address_i`.
- `AXI_DATA_WIDTH`, 64: data width; only 64 is supported.
- `clk_i` in 1: clock. Reset is `rst_ni`, asynchronous, active-low; clock is `clk_i`.
- `rst_ni` in 1: asynchronous active-low reset.
- `rtc_i` in 1: real-time clock, asynchronous to `clk_i`, much slower than `clk_i`.
- `en_i` in 1: access valid this cycle.
- `we_i` in 1: 1 = write, 0 = read. Meaningful only with `en_i`.
- `address_i` in AXI_ADDR_WIDTH: byte address. Only bits [15:3] are decoded; bits [2:0] are ignored.
- `wdata_i` in 64: write data. Full-word writes only; no strobes.
- `rdata_o` out 64: read data.
- `timer_irq_o` out NR_CORES: machine timer interrupt per hart.
- `ipi_o` out NR_CORES: machine software interrupt per hart.

## Operation
- Map, by 64-bit word offset (address bits [15:0]):
  - MSIP at 0x0000 + 8·k holds hart 2k in bit 0 and hart 2k+1 in bit 32.
  - MTIMECMP[i] at 0x4000 + 8·i.
  - MTIME at 0xBFF8.
- Reads:
  - `rdata_o` is a purely combinational decode of `address_i` over the current register values, whenever `en_i`=1 and `we_i`=0.
  - Otherwise `rdata_o`='0.
  - Unmapped addresses, or harts ≥ NR_CORES, read '0.
  - Non-writable MSIP bits read 0.
- Writes:
  - Take effect at the clock edge ending the `en_i`&`we_i` cycle.
  - MSIP: only bits 0 and 32 are stored.
  - Writes to unmapped addresses are dropped silently.
- RTC path:
  - `rtc_i` is passed through a 2-flop synchronizer.
  - Each rising edge of the synchronized signal yields a one-cycle `tick`.
  - On `tick`, `mtime` += 1, wrapping modulo 2^64.
- Write vs. tick in the same cycle: the software write to MTIME wins and the tick is lost.
- `ipi_o[i]` is the stored MSIP bit for hart i (registered).
- `timer_irq_o[i]` is a register loaded each cycle with (`mtime_q` ≥ `mtimecmp_q[i]`), unsigned 64-bit compare.
- The interrupt is level-sensitive. It clears only after `mtimecmp` is raised above `mtime` or `mtime` is rewritten lower.

## Timing
- Reset values:
  - `mtime` = 0; every `mtimecmp` = all-ones; MSIP = 0.
  - Synchronizer flops = 0.
  - `timer_irq_o` = 0; `ipi_o` = 0; `rdata_o` = 0 (no access).
- Read latency: 0 cycles. Data is valid in the same cycle as `en_i` and is sampled by the upstream slave in that cycle.
- Write to MSIP: `ipi_o` changes 1 cycle after the write cycle.
- Write to MTIMECMP or MTIME: `timer_irq_o` reflects the new value 2 cycles after the write cycle (register update, then compare register).
- RTC: `mtime` increments 3 `clk_i` cycles after the `rtc_i` rising edge (2 sync flops + edge register).
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronous). The first tick after deassertion requires a fresh rising edge of `rtc_i`; a high level at release does not count.
- A read of MTIME in the same cycle as a tick returns the pre-increment value.

## Structure
- `clint_pkg` contains:
  - `MSIP_BASE` = 16'h0000, `MTIMECMP_BASE` = 16'h4000, `MTIME_BASE` = 16'hBFF8.
  - The tick-related constant `RTC_SYNC_STAGES` = 2.
- Sub-module `clint_rtc_sync` holds the 2-flop synchronizer plus rising-edge detector. It outputs `tick_o` and is reset asynchronously to 0.
- The regfile instantiates it once. The decode, registers and comparators stay in `clint_regfile`.

## Test plan
- Reset, then read 0xBFF8, 0x4000 and 0x0000 → 0, 64'hFFFF_FFFF_FFFF_FFFF and 0. All interrupt outputs stay 0.
- NR_CORES=2:
  - Write 64'h0000_0001_0000_0001 to 0x0000 → `ipi_o`=2'b11 one cycle later.
  - Readback gives the same value.
  - Writing 64'hFFFF_FFFE_FFFF_FFFE → `ipi_o`=0; readback 0.
- Toggle `rtc_i` 5 times (period 10 clocks) → MTIME reads 5. Each increment lands 3 cycles after the `rtc_i` rise.
- Write MTIMECMP[1] (0x4008) = 3 with `mtime`=0, then tick 3 times → `timer_irq_o[1]` rises 1 cycle after `mtime` becomes 3. Writing 0x4008 = 10 drops it 2 cycles later.
- Write MTIME = 64'hFFFF_FFFF_FFFF_FFFF, then tick → MTIME reads 0.
  - Write MTIME = 7 in the same cycle as a tick → MTIME reads 7.
- Read 0x8000 → 0. Write 0x8000, then read back all mapped registers → unchanged.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared constants, register-region decode types and the address decode helper
// for the CLINT register bank.
package clint_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

  localparam int unsigned RTC_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    REG_NONE     = 2'd0,
    REG_MSIP     = 2'd1,
    REG_MTIMECMP = 2'd2,
    REG_MTIME    = 2'd3
  } clint_reg_e;

  typedef struct packed {
    clint_reg_e  region;
    logic [12:0] idx;
  } clint_dec_t;

  // Word index below a region base wraps to a huge value, so one upper bound
  // check per region is enough.
  function automatic clint_dec_t clint_decode(input logic [15:0] addr,
                                              input int unsigned nr_cores);
    clint_dec_t  dec;
    logic [12:0] word;
    logic [12:0] cmp_idx;
    logic [12:0] msip_idx;
    word     = addr[15:3];
    cmp_idx  = word - MTIMECMP_BASE[15:3];
    msip_idx = word - MSIP_BASE[15:3];
    dec.region = REG_NONE;
    dec.idx    = 13'd0;
    if (word == MTIME_BASE[15:3]) begin
      dec.region = REG_MTIME;
    end else if (32'(cmp_idx) < nr_cores) begin
      dec.region = REG_MTIMECMP;
      dec.idx    = cmp_idx;
    end else if (32'(msip_idx) < (nr_cores + 32'd1) / 32'd2) begin
      dec.region = REG_MSIP;
      dec.idx    = msip_idx;
    end else begin
      dec.region = REG_NONE;
    end
    return dec;
  endfunction

endpackage

// File: rtl/clint_rtc_sync.sv
// Brings the slow asynchronous RTC into the clk_i domain and emits a one-cycle
// tick per synchronized rising edge.
module clint_rtc_sync
  import clint_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rtc_i,
  output logic tick_o
);

  localparam int unsigned TOP = RTC_SYNC_STAGES - 1;

  logic [RTC_SYNC_STAGES-1:0] sync_q;
  logic [RTC_SYNC_STAGES-1:0] vld_q;
  logic                       prev_q;

  // Synchronizer chain plus edge register; prev_q is held high until the
  // chain carries real samples, so a level already high at reset release is
  // never taken as an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      vld_q  <= '0;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[RTC_SYNC_STAGES-2:0], rtc_i};
      vld_q  <= {vld_q[RTC_SYNC_STAGES-2:0], 1'b1};
      prev_q <= vld_q[TOP] ? sync_q[TOP] : 1'b1;
    end
  end

  assign tick_o = sync_q[TOP] & ~prev_q;

endmodule

// File: rtl/clint_regfile.sv
// CLINT register bank: MSIP, per-hart MTIMECMP and the shared MTIME counter,
// with RAM-like access, zero-latency reads and registered interrupt outputs.
module clint_regfile
  import clint_pkg::*;
#(
  parameter int unsigned NR_CORES       = 1,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      rtc_i,
  input  logic                      en_i,
  input  logic                      we_i,
  input  logic [AXI_ADDR_WIDTH-1:0] address_i,
  input  logic [AXI_DATA_WIDTH-1:0] wdata_i,
  output logic [AXI_DATA_WIDTH-1:0] rdata_o,
  output logic [NR_CORES-1:0]       timer_irq_o,
  output logic [NR_CORES-1:0]       ipi_o
);

  logic                      tick_s;
  clint_dec_t                dec_s;
  logic                      unused_addr_s;
  logic [NR_CORES-1:0]       msip_q, msip_d;
  logic [NR_CORES-1:0]       irq_q, irq_d;
  logic [NR_CORES-1:0][63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0]               mtime_q, mtime_d;

  clint_rtc_sync u_rtc_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rtc_i  (rtc_i),
    .tick_o (tick_s)
  );

  assign dec_s         = clint_decode(address_i[15:0], NR_CORES);
  assign unused_addr_s = ^{address_i[AXI_ADDR_WIDTH-1:16], address_i[2:0]};

  // Next state: a software write to MTIME overrides a coincident tick.
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick_s ? mtime_q + 64'd1 : mtime_q;
    for (int unsigned i = 0; i < NR_CORES; i++) begin
      irq_d[i] = (mtime_q >= mtimecmp_q[i]);
    end
    if (en_i && we_i) begin
      case (dec_s.region)
        REG_MSIP: begin
          for (int unsigned i = 0; i < NR_CORES; i++) begin
            msip_d[i] = (i / 32'd2 == 32'(dec_s.idx)) ? wdata_i[32 * (i % 2)] : msip_q[i];
          end
        end
        REG_MTIMECMP: begin
          for (int unsigned i = 0; i < NR_CORES; i++) begin
            mtimecmp_d[i] = (i == 32'(dec_s.idx)) ? wdata_i : mtimecmp_q[i];
          end
        end
        REG_MTIME: mtime_d = wdata_i;
        default:   mtime_d = mtime_d;
      endcase
    end else begin
      msip_d = msip_q;
    end
  end

  // Combinational read decode over current register values.
  always_comb begin
    rdata_o = '0;
    if (en_i && !we_i) begin
      case (dec_s.region)
        REG_MSIP: begin
          for (int unsigned i = 0; i < NR_CORES; i++) begin
            rdata_o[32 * (i % 2)] = (i / 32'd2 == 32'(dec_s.idx)) ? msip_q[i]
                                                                  : rdata_o[32 * (i % 2)];
          end
        end
        REG_MTIMECMP: begin
          for (int unsigned i = 0; i < NR_CORES; i++) begin
            rdata_o = (i == 32'(dec_s.idx)) ? mtimecmp_q[i] : rdata_o;
          end
        end
        REG_MTIME: rdata_o = mtime_q;
        default:   rdata_o = '0;
      endcase
    end else begin
      rdata_o = '0;
    end
  end

  // Architectural state and interrupt registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      msip_q     <= '0;
      irq_q      <= '0;
      mtimecmp_q <= '1;
      mtime_q    <= 64'd0;
    end else begin
      msip_q     <= msip_d;
      irq_q      <= irq_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
    end
  end

  assign ipi_o       = msip_q;
  assign timer_irq_o = irq_q;

endmodule
